// File: rtl/mult_sequencer.sv
// Multi-cycle shift-add MULT/MULTU sequencer for the execute stage.
// Drives an external ripple adder and accumulates the 64-bit product in hi/lo.
module mult_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABS_A,
      S_ABS_B,
      S_MUL,
      S_NEG_LO,
      S_NEG_HI,
      S_DONE
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] mcand;
   logic [CW-1:0]    cnt;
   logic             sgn;
   logic             neg;
   logic             carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      add_a    = '0;
      add_b    = '0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = is_signed ? S_ABS_A : S_MUL;
         end
         S_ABS_A: begin
            add_a    = mcand[WIDTH-1] ? ~mcand : mcand;
            add_b    = WIDTH'(mcand[WIDTH-1]);
            state_nx = S_ABS_B;
         end
         S_ABS_B: begin
            add_a    = lo[WIDTH-1] ? ~lo : lo;
            add_b    = WIDTH'(lo[WIDTH-1]);
            state_nx = S_MUL;
         end
         S_MUL: begin
            add_a = hi;
            add_b = lo[0] ? mcand : '0;
            if (cnt == CW'(WIDTH - 1)) state_nx = sgn ? S_NEG_LO : S_DONE;
         end
         S_NEG_LO: begin
            // Two's-complement negation split across two adder passes; carry links them.
            add_a    = neg ? ~lo : lo;
            add_b    = WIDTH'(neg);
            state_nx = S_NEG_HI;
         end
         S_NEG_HI: begin
            add_a    = neg ? ~hi : hi;
            add_b    = WIDTH'(carry);
            state_nx = S_DONE;
         end
         S_DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         sgn   <= 1'b0;
         neg   <= 1'b0;
         carry <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand <= op_a;
                  hi    <= '0;
                  lo    <= op_b;
                  sgn   <= is_signed;
                  neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  cnt   <= '0;
               end
            end
            S_ABS_A: mcand <= add_sum;
            S_ABS_B: lo    <= add_sum;
            S_MUL: begin
               {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
               cnt      <= cnt + CW'(1);
            end
            S_NEG_LO: begin
               lo    <= add_sum;
               carry <= add_cout & neg;
            end
            S_NEG_HI: hi <= add_sum;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: behavioural adder, cycle-count model of the
// handshake, 64-bit arithmetic reference for the product, directed and random operations.
module tb_mult_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_cout;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mult_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_cout(add_cout), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   // external ripple adder stand-in
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   initial forever #5 clk = ~clk;

   function automatic logic [63:0] ref_prod(input bit sg, input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      if (sg) begin
         pa = longint'($signed(a));
         pb = longint'($signed(b));
      end else begin
         pa = longint'({32'b0, a});
         pb = longint'({32'b0, b});
      end
      return 64'(pa * pb);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // model: remaining-cycle countdown, product from plain arithmetic
   bit          m_active = 1'b0;
   bit          m_dcyc = 1'b0;
   int          m_left = 0;
   logic [63:0] m_res = '0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_active = 1'b0; m_dcyc = 1'b0; m_left = 0; m_hi = '0; m_lo = '0;
      end else if (m_dcyc) begin
         m_dcyc = 1'b0;
      end else if (m_active) begin
         m_left--;
         if (m_left == 0) begin
            m_active = 1'b0;
            m_dcyc   = 1'b1;
            {m_hi, m_lo} = m_res;
         end
      end else if (start) begin
         m_active = 1'b1;
         m_left   = is_signed ? 36 : 32;
         m_res    = ref_prod(is_signed, op_a, op_b);
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("cyc_busy", 64'(busy), 64'(m_active));
         chk("cyc_done", 64'(done), 64'(m_dcyc));
         if (!m_active) begin
            chk("cyc_hi", 64'(hi), 64'(m_hi));
            chk("cyc_lo", 64'(lo), 64'(m_lo));
         end
      end
   end

   task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int elat,
                         input bit inject, input string nm);
      int first, ndone, nbusy;
      first = -1; ndone = 0; nbusy = 0;
      @(negedge clk);
      start = 1'b1; is_signed = sg; op_a = a; op_b = b;
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         if (inject && (j == 5 || j == 20)) begin
            start = 1'b1; is_signed = 1'($urandom); op_a = $urandom; op_b = $urandom;
         end else begin
            start = 1'b0; op_a = $urandom; op_b = $urandom;
         end
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (first < 0) first = j;
         end
      end
      chk({nm, "_latency"}, 64'(first + 1), 64'(elat));
      chk({nm, "_ndone"}, 64'(ndone), 64'd1);
      chk({nm, "_busycyc"}, 64'(nbusy), 64'(elat - 1));
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      logic [63:0] p;
      bit          sg;
      logic [31:0] a, b;

      #1 rst = 1'b1;
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // hand-computed products pin both the model and the DUT
      chk("model_pin", ref_prod(1'b1, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
      run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0, "multu_max");
      run_op(1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 37, 1'b0, "mult_m3x7");
      run_op(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 37, 1'b0, "mult_min_sq");
      run_op(1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 37, 1'b0, "mult_min_x1");
      run_op(1'b0, 32'd0,        32'h12345678, 32'd0,        32'd0,        33, 1'b0, "multu_zero");
      run_op(1'b1, 32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        37, 1'b0, "mult_m1x0");
      run_op(1'b0, 32'd6,        32'd7,        32'd0,        32'd42,       33, 1'b1, "multu_ignore_start");

      // reset in the middle of a signed multiply
      @(negedge clk);
      start = 1'b1; is_signed = 1'b1; op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0, "multu_after_rst");

      for (int i = 0; i < 30; i++) begin
         sg = 1'($urandom);
         a  = $urandom;
         b  = $urandom;
         if (i % 5 == 0) a = {a[31], 31'($urandom_range(0, 3))};
         p  = ref_prod(sg, a, b);
         run_op(sg, a, b, p[63:32], p[31:0], sg ? 37 : 33, 1'($urandom_range(0, 1)), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
